// File: rtl/feed_pkg.sv
// ---------------------------------------------------------------------------
// feed_pkg
// Shared definitions for the pet-feeder scheduler.
//   state_t      : controller state (2-bit encoding)
//   COUNT_W      : width of the seconds countdown / interval
//   PORT_W       : width of the delivered-portion counter
//   reload_value : countdown reload rule (an interval of 0 is treated as 1 s)
// ---------------------------------------------------------------------------
package feed_pkg;

    localparam int COUNT_W = 16;
    localparam int PORT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    // An interval of 0 would never expire, so the shortest usable period is 1 s.
    function automatic logic [COUNT_W-1:0] reload_value(input logic [COUNT_W-1:0] interval);
        return (interval == '0) ? COUNT_W'(1) : interval;
    endfunction

endpackage

// File: rtl/feed_scheduler_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle 1 s tick.
//   clk   in  clock
//   reset in  synchronous, active-high reset (counter to 0)
//   tick  out high for the single cycle in which the counter equals TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/feed_scheduler.sv
// ---------------------------------------------------------------------------
// feed_scheduler
// Timed / manual feed controller with bowl interlock, daily portion limit and
// dispenser timeout.
//   clk, reset            clock, synchronous active-high reset
//   auto_en               enable timed feeding
//   interval_s[15:0]      seconds between automatic feeds (sampled on reload)
//   manual_req            one-cycle manual portion request
//   bowl_full             blocks any dispense while high
//   disp_done             one-cycle pulse: dispenser finished a portion
//   portions_clr          one-cycle pulse: clear portion count
//   fault_clr             one-cycle pulse: leave FAULT
//   disp_start            one-cycle pulse commanding one portion
//   countdown[15:0]       seconds to next automatic feed (0 when not counting)
//   portions[3:0]         portions delivered since last clear (saturating)
//   busy / fault          high in DISPENSE / FAULT
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module feed_scheduler
    import feed_pkg::*;
#(
    parameter int TICK_DIV     = 50000000,
    parameter int TIMEOUT_S    = 10,
    parameter int MAX_PORTIONS = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               auto_en,
    input  logic [15:0]        interval_s,
    input  logic               manual_req,
    input  logic               bowl_full,
    input  logic               disp_done,
    input  logic               portions_clr,
    input  logic               fault_clr,
    output logic               disp_start,
    output logic [15:0]        countdown,
    output logic [3:0]         portions,
    output logic               busy,
    output logic               fault
);

    localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT_S - 1);
    localparam logic [PORT_W-1:0] PORT_MAX  = PORT_W'(MAX_PORTIONS);

    logic               tick;
    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] countdown_reg, countdown_next;
    logic [PORT_W-1:0]  portions_reg, portions_next;
    logic [7:0]         timeout_reg, timeout_next;
    logic               disp_start_reg, disp_start_next;
    logic               busy_reg, fault_reg;

    logic               allowed;
    logic               expiry;
    logic [PORT_W-1:0]  portions_inc;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign allowed      = !bowl_full && (portions_reg < PORT_MAX);
    assign expiry       = tick && (countdown_reg == COUNT_W'(1));
    assign portions_inc = (portions_reg == '1) ? portions_reg : portions_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        countdown_next  = countdown_reg;
        portions_next   = portions_reg;
        timeout_next    = timeout_reg;
        disp_start_next = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                countdown_next = '0;
                if (manual_req && allowed) begin
                    state_next      = ST_DISPENSE;
                    disp_start_next = 1'b1;
                    timeout_next    = '0;
                end else if (auto_en) begin
                    state_next     = ST_COUNT;
                    countdown_next = reload_value(interval_s);
                end
            end

            ST_COUNT: begin
                if (!auto_en) begin
                    state_next     = ST_IDLE;
                    countdown_next = '0;
                end else if ((manual_req && allowed) || (expiry && allowed)) begin
                    // A manual request landing on expiry merges into one dispense.
                    state_next      = ST_DISPENSE;
                    disp_start_next = 1'b1;
                    timeout_next    = '0;
                    countdown_next  = '0;
                end else if (expiry) begin
                    // Feed skipped (bowl full or limit reached): start a new period.
                    countdown_next = reload_value(interval_s);
                end else if (tick && countdown_reg != '0) begin
                    countdown_next = countdown_reg - 1'b1;
                end
            end

            ST_DISPENSE: begin
                countdown_next = '0;
                if (disp_done) begin
                    portions_next = portions_inc;
                    if (auto_en) begin
                        state_next     = ST_COUNT;
                        countdown_next = reload_value(interval_s);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (tick) begin
                    timeout_next = timeout_reg + 1'b1;
                    if (timeout_reg == TO_LAST) begin
                        state_next = ST_FAULT;
                    end
                end
            end

            ST_FAULT: begin
                countdown_next = '0;
                if (fault_clr) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                countdown_next = '0;
            end
        endcase

        // Daily rollover wins over the count, except a portion finishing in the
        // same cycle belongs to the new day.
        if (portions_clr) begin
            portions_next = (state_reg == ST_DISPENSE && disp_done) ? PORT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            countdown_reg  <= '0;
            portions_reg   <= '0;
            timeout_reg    <= '0;
            disp_start_reg <= 1'b0;
            busy_reg       <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            countdown_reg  <= countdown_next;
            portions_reg   <= portions_next;
            timeout_reg    <= timeout_next;
            disp_start_reg <= disp_start_next;
            busy_reg       <= (state_next == ST_DISPENSE);
            fault_reg      <= (state_next == ST_FAULT);
        end
    end

    assign disp_start = disp_start_reg;
    assign countdown  = countdown_reg;
    assign portions   = portions_reg;
    assign busy       = busy_reg;
    assign fault      = fault_reg;

endmodule

// File: tb/tb_feed_scheduler.sv
// ---------------------------------------------------------------------------
// tb_feed_scheduler
// Directed bench for feed_scheduler (TICK_DIV=4, TIMEOUT_S=3, MAX_PORTIONS=2).
// A behavioural model of the feeder rules runs alongside the DUT and every
// output is compared on every cycle; directed scenarios add hand-computed
// literal expectations.
// ---------------------------------------------------------------------------
module tb_feed_scheduler;

    localparam int TDIV  = 4;
    localparam int TOUT  = 3;
    localparam int MAXP  = 2;

    logic        clk = 1'b0;
    logic        reset, auto_en, manual_req, bowl_full, disp_done, portions_clr, fault_clr;
    logic [15:0] interval_s;
    logic        disp_start, busy, fault;
    logic [15:0] countdown;
    logic [3:0]  portions;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    feed_scheduler #(.TICK_DIV(TDIV), .TIMEOUT_S(TOUT), .MAX_PORTIONS(MAXP)) dut (
        .clk(clk), .reset(reset), .auto_en(auto_en), .interval_s(interval_s),
        .manual_req(manual_req), .bowl_full(bowl_full), .disp_done(disp_done),
        .portions_clr(portions_clr), .fault_clr(fault_clr), .disp_start(disp_start),
        .countdown(countdown), .portions(portions), .busy(busy), .fault(fault)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_COUNT = 1, M_DISP = 2, M_FAULT = 3;
    int m_mode = M_IDLE;
    int m_cd = 0, m_port = 0, m_secs = 0, m_start = 0;
    int m_edges = 0;          // clock edges since reset released

    task automatic model_step();
        bit tk, ok, was_disp;
        int rl;
        if (reset) begin
            m_mode = M_IDLE; m_cd = 0; m_port = 0; m_secs = 0; m_start = 0; m_edges = 0;
            return;
        end
        tk = (m_edges % TDIV) == TDIV - 1;
        m_edges++;
        ok = !bowl_full && (m_port < MAXP);
        rl = (interval_s == 0) ? 1 : int'(interval_s);
        was_disp = (m_mode == M_DISP);
        m_start = 0;
        if (m_mode == M_IDLE) begin
            if (manual_req && ok) begin m_mode = M_DISP; m_start = 1; m_secs = 0; m_cd = 0; end
            else if (auto_en)     begin m_mode = M_COUNT; m_cd = rl; end
            else m_cd = 0;
        end else if (m_mode == M_COUNT) begin
            if (!auto_en) begin m_mode = M_IDLE; m_cd = 0; end
            else if (manual_req && ok) begin m_mode = M_DISP; m_start = 1; m_secs = 0; m_cd = 0; end
            else if (tk) begin
                if (m_cd == 1) begin
                    if (ok) begin m_mode = M_DISP; m_start = 1; m_secs = 0; m_cd = 0; end
                    else m_cd = rl;
                end else m_cd = m_cd - 1;
            end
        end else if (m_mode == M_DISP) begin
            if (disp_done) begin
                m_port = (m_port >= 15) ? 15 : m_port + 1;
                if (auto_en) begin m_mode = M_COUNT; m_cd = rl; end
                else m_mode = M_IDLE;
            end else if (tk) begin
                m_secs++;
                if (m_secs >= TOUT) m_mode = M_FAULT;
            end
        end else begin
            if (fault_clr) m_mode = M_IDLE;
        end
        if (portions_clr) m_port = (was_disp && disp_done) ? 1 : 0;
    endtask

    // Single compare process: model advances on the edge, outputs checked 1 time unit later.
    always @(posedge clk) begin
        model_step();
        #1;
        check("disp_start", int'(disp_start), m_start);
        check("countdown",  int'(countdown),  m_cd);
        check("portions",   int'(portions),   m_port);
        check("busy",       int'(busy),       int'(m_mode == M_DISP));
        check("fault",      int'(fault),      int'(m_mode == M_FAULT));
        if (disp_start) n_starts++;
    end

    // ---------------- stimulus helpers ----------------
    localparam int P_MANUAL = 0, P_DONE = 1, P_CLR = 2, P_FCLR = 3;
    localparam int S_CD = 0, S_BUSY = 1, S_FAULT = 2, S_PORT = 3;

    function automatic int dut_sig(input int sel);
        case (sel)
            S_CD:    return int'(countdown);
            S_BUSY:  return int'(busy);
            S_FAULT: return int'(fault);
            default: return int'(portions);
        endcase
    endfunction

    task automatic pulse(input int sel);
        case (sel)
            P_MANUAL: manual_req   = 1'b1;
            P_DONE:   disp_done    = 1'b1;
            P_CLR:    portions_clr = 1'b1;
            default:  fault_clr    = 1'b1;
        endcase
        @(negedge clk);
        manual_req = 1'b0; disp_done = 1'b0; portions_clr = 1'b0; fault_clr = 1'b0;
        @(negedge clk);
    endtask

    // Bounded wait; the final comparison fails if the value never appears.
    task automatic wait_until(input string name, input int sel, input int val, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (dut_sig(sel) == val) break;
            @(negedge clk);
        end
        check(name, dut_sig(sel), val);
    endtask

    int s0;

    initial begin
        reset = 1'b1; auto_en = 1'b0; interval_s = 16'd3; manual_req = 1'b0;
        bowl_full = 1'b0; disp_done = 1'b0; portions_clr = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_countdown", int'(countdown), 0);
        check("reset_portions", int'(portions), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_start", int'(disp_start), 0);

        // Timed feed: 3,2,1 then one dispense, completion reloads 3.
        reset = 1'b0; auto_en = 1'b1;
        @(negedge clk);
        $display("auto feed: enable, countdown=%0d", countdown);
        check("auto_load3", int'(countdown), 3);
        wait_until("auto_cd2", S_CD, 2, 8);
        wait_until("auto_cd1", S_CD, 1, 8);
        s0 = n_starts;
        wait_until("auto_busy", S_BUSY, 1, 8);
        check("auto_one_start", n_starts - s0, 1);
        check("auto_cd0_in_disp", int'(countdown), 0);
        pulse(P_DONE);
        $display("auto feed: done, portions=%0d countdown=%0d", portions, countdown);
        check("auto_portions1", int'(portions), 1);
        check("auto_reload3", int'(countdown), 3);
        check("auto_not_busy", int'(busy), 0);

        // Bowl full at expiry: skip and reload.
        bowl_full = 1'b1; s0 = n_starts;
        wait_until("bowl_cd1", S_CD, 1, 12);
        wait_until("bowl_reload3", S_CD, 3, 8);
        $display("bowl full: starts=%0d portions=%0d", n_starts - s0, portions);
        check("bowl_no_start", n_starts - s0, 0);
        check("bowl_portions", int'(portions), 1);
        bowl_full = 1'b0;

        // Manual request exactly on the expiry edge: single dispense.
        wait_until("coinc_cd1", S_CD, 1, 12);
        while ((m_edges % TDIV) != TDIV - 1) @(negedge clk);
        s0 = n_starts;
        pulse(P_MANUAL);
        repeat (2) @(negedge clk);
        $display("coincident manual+expiry: starts=%0d", n_starts - s0);
        check("coinc_one_start", n_starts - s0, 1);
        check("coinc_busy", int'(busy), 1);
        pulse(P_DONE);
        check("limit_portions2", int'(portions), 2);

        // At the limit: manual and expiry both refused.
        s0 = n_starts;
        pulse(P_MANUAL);
        wait_until("limit_cd1", S_CD, 1, 12);
        wait_until("limit_reload3", S_CD, 3, 8);
        pulse(P_MANUAL);
        $display("limit reached: starts=%0d portions=%0d", n_starts - s0, portions);
        check("limit_no_start", n_starts - s0, 0);
        pulse(P_CLR);
        check("clr_portions0", int'(portions), 0);
        auto_en = 1'b0;
        @(negedge clk);
        s0 = n_starts;
        pulse(P_MANUAL);
        $display("after clear: manual starts=%0d busy=%0d", n_starts - s0, busy);
        check("clr_then_start", n_starts - s0, 1);
        check("clr_then_busy", int'(busy), 1);

        // Dispenser never reports: fault after 3 ticks.
        wait_until("timeout_fault", S_FAULT, 1, 20);
        $display("timeout: fault=%0d busy=%0d", fault, busy);
        check("timeout_busy0", int'(busy), 0);
        pulse(P_FCLR);
        check("fclr_fault0", int'(fault), 0);
        check("fclr_busy0", int'(busy), 0);

        // Bowl full also blocks manual requests.
        bowl_full = 1'b1; s0 = n_starts;
        pulse(P_MANUAL);
        check("bowl_manual_blocked", n_starts - s0, 0);
        bowl_full = 1'b0;

        // Interval 0 loads 1.
        interval_s = 16'd0; auto_en = 1'b1;
        @(negedge clk);
        $display("interval 0: countdown=%0d", countdown);
        check("interval0_load1", int'(countdown), 1);
        auto_en = 1'b0;
        @(negedge clk);
        check("auto_off_cd0", int'(countdown), 0);
        interval_s = 16'd3;

        // portions_clr together with disp_done -> 1.
        pulse(P_MANUAL);
        disp_done = 1'b1; portions_clr = 1'b1;
        @(negedge clk);
        disp_done = 1'b0; portions_clr = 1'b0;
        $display("clr+done: portions=%0d", portions);
        check("clr_done_portions1", int'(portions), 1);

        // Reset in the middle of a dispense.
        pulse(P_MANUAL);
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        $display("reset mid-dispense: busy=%0d portions=%0d start=%0d", busy, portions, disp_start);
        check("rst_busy0", int'(busy), 0);
        check("rst_portions0", int'(portions), 0);
        check("rst_start0", int'(disp_start), 0);
        check("rst_fault0", int'(fault), 0);
        reset = 1'b0;
        @(negedge clk);
        pulse(P_DONE);
        check("late_done_ignored", int'(portions), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/feed_scheduler.md
FEED_SCHEDULER -- requirements
Module: feed_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per 1 s tick (>=2).
REQ-002 Parameter TIMEOUT_S, default 10, seconds allowed in DISPENSE before fault (1..255).
REQ-003 Parameter MAX_PORTIONS, default 6, portions allowed between portions_clr pulses (1..15).
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 auto_en  in  1  level; 1 = timed feeding enabled.
REQ-007 interval_s  in  16  seconds between automatic feeds; sampled at each reload.
REQ-008 manual_req  in  1  one-cycle request pulse for a manual portion (already debounced).
REQ-009 bowl_full  in  1  level from bowl sensor; 1 blocks any dispense.
REQ-010 disp_done  in  1  one-cycle pulse from dispenser: portion delivered.
REQ-011 portions_clr  in  1  one-cycle pulse; clears portion count (daily rollover).
REQ-012 fault_clr  in  1  one-cycle pulse; leaves FAULT.
REQ-013 disp_start  out  1  one-cycle pulse commanding one portion.
REQ-014 countdown  out  16  seconds remaining to next automatic feed; 0 when not counting.
REQ-015 portions  out  4  portions delivered since last clear, saturating at 15.
REQ-016 busy  out  1  1 while in DISPENSE.
REQ-017 fault  out  1  1 while in FAULT.

Function
REQ-018 Tick: free-running counter 0..TICK_DIV-1; tick high for one cycle when counter = TICK_DIV-1, then wraps to 0.
REQ-019 States: IDLE, COUNT, DISPENSE, FAULT; all outputs registered.
REQ-020 "Allowed" = !bowl_full and portions < MAX_PORTIONS.
REQ-021 Reload: countdown <= interval_s, or 1 if interval_s = 0.
REQ-022 IDLE: manual_req and allowed -> DISPENSE; else auto_en -> COUNT with reload; else stay, countdown = 0.
REQ-023 COUNT: auto_en low -> IDLE, countdown <= 0 (takes priority over all other COUNT events).
REQ-024 COUNT: on tick, countdown decrements by 1; on tick with countdown = 1: if allowed -> DISPENSE, else reload and stay (feed skipped).
REQ-025 COUNT: manual_req and allowed -> DISPENSE; manual_req coinciding with expiry yields exactly one dispense.
REQ-026 Entering DISPENSE: disp_start = 1 for exactly the first cycle in DISPENSE (one cycle after the decision edge); timeout counter cleared.
REQ-027 DISPENSE: timeout counter increments on tick; disp_done -> portions +1 (saturate 15), then COUNT with reload if auto_en, else IDLE.
REQ-028 DISPENSE: timeout counter reaches TIMEOUT_S without disp_done -> FAULT; disp_done in the same cycle wins (normal completion).
REQ-029 DISPENSE: manual_req, bowl_full and auto_en changes ignored; countdown holds 0.
REQ-030 FAULT: disp_start never asserted; fault_clr -> IDLE; other inputs ignored.
REQ-031 portions_clr zeros portions in any state; with disp_done same cycle, result = 1.
REQ-032 disp_done outside DISPENSE ignored.

Reset
REQ-033 reset high at rising edge: state IDLE; disp_start 0, countdown 0, portions 0, busy 0, fault 0; tick and timeout counters 0; reset overrides every other input, including mid-DISPENSE.

Structure
REQ-034 Shared package feed_pkg holds state enum (2-bit), COUNT_W = 16, PORT_W = 4.
REQ-035 One sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick) implements REQ-018.

Verification (TICK_DIV = 4, TIMEOUT_S = 3, MAX_PORTIONS = 2)
REQ-036 auto_en = 1, interval_s = 3 -> countdown 3,2,1 on successive ticks; disp_start one pulse; disp_done -> portions = 1, countdown = 3.
REQ-037 bowl_full = 1 at expiry -> no disp_start, countdown reloads to 3, portions unchanged.
REQ-038 DISPENSE with no disp_done for 3 ticks -> fault = 1, busy = 0; fault_clr -> IDLE, fault = 0.
REQ-039 Two completed feeds -> portions = 2; further manual_req and expiry produce no disp_start; portions_clr -> 0, next request dispenses.
REQ-040 manual_req same cycle as expiry -> single disp_start; interval_s = 0 -> countdown loads 1.
REQ-041 reset asserted mid-DISPENSE -> all outputs 0 next cycle; later disp_done ignored.
